// File: rtl/video_pkg.sv
// Shared encodings and colour constants for the video pattern generator.
package video_pkg;

  typedef enum logic [1:0] {
    MODE_GRADIENT = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_SOLID    = 2'd3
  } mode_e;

  localparam logic [7:0]  GRAD_BLUE = 8'h5A;
  localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
  localparam logic [23:0] RGB_BLACK = 24'h000000;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_TABLE = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical position counters with combinational sync, active-video and pulse decode.
module video_timing_counter
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic [CW-1:0] h,
  output logic [CW-1:0] v,
  output logic          hsync_on,
  output logic          vsync_on,
  output logic          active,
  output logic          pulse_line,
  output logic          pulse_frame,
  output logic          line_end,
  output logic          frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEGIN = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEGIN = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (enable) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Every decode is gated by enable so a frozen generator presents an idle raster.
  always_comb begin
    line_end    = enable && (h == H_LAST);
    frame_end   = line_end && (v == V_LAST);
    hsync_on    = enable && (h >= HS_BEGIN) && (h < HS_END);
    vsync_on    = enable && (v >= VS_BEGIN) && (v < VS_END);
    active      = enable && (h < H_ACT) && (v < V_ACT);
    pulse_line  = enable && (h == '0);
    pulse_frame = enable && (h == '0) && (v == '0);
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Parametrised video timing generator with selectable test patterns and a single output register stage.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE   = 1920,
  parameter int H_FP       = 88,
  parameter int H_SYNC     = 44,
  parameter int H_BP       = 148,
  parameter int V_ACTIVE   = 1080,
  parameter int V_FP       = 4,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 36,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int CHECK_LOG2 = 5,
  parameter int CW         = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [1:0]    mode,
  input  logic [23:0]   solid_rgb,
  output logic [CW-1:0] hdata,
  output logic [CW-1:0] vdata,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic          frame_start,
  output logic          line_start
);

  localparam int            BAR_W    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

  logic [CW-1:0] h, v;
  logic          hsync_on, vsync_on, active;
  logic          pulse_line, pulse_frame, line_end, frame_end;

  mode_e         shadow_mode;
  logic [23:0]   shadow_rgb;
  logic [2:0]    bar_idx;
  logic [CW-1:0] bar_cnt;
  logic [23:0]   pix;

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CW       (CW)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .h           (h),
    .v           (v),
    .hsync_on    (hsync_on),
    .vsync_on    (vsync_on),
    .active      (active),
    .pulse_line  (pulse_line),
    .pulse_frame (pulse_frame),
    .line_end    (line_end),
    .frame_end   (frame_end)
  );

  always_comb begin
    pix = '0;
    case (shadow_mode)
      MODE_GRADIENT: pix = {h[7:0], v[7:0], GRAD_BLUE};
      MODE_BARS:     pix = BAR_TABLE[bar_idx];
      MODE_CHECKER:  pix = (h[CHECK_LOG2] ^ v[CHECK_LOG2]) ? RGB_WHITE : RGB_BLACK;
      MODE_SOLID:    pix = shadow_rgb;
      default:       pix = '0;
    endcase
  end

  // Shadows load on the edge that wraps the raster to (0,0), so the whole new frame,
  // pixel (0,0) included, sees one consistent mode/colour.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_mode <= MODE_GRADIENT;
      shadow_rgb  <= '0;
      bar_idx     <= '0;
      bar_cnt     <= '0;
      hdata       <= '0;
      vdata       <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      {red, green, blue} <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      if (frame_end) begin
        shadow_mode <= mode_e'(mode);
        shadow_rgb  <= solid_rgb;
      end

      if (line_end) begin
        bar_idx <= '0;
        bar_cnt <= '0;
      end else if (enable) begin
        if (bar_cnt == BAR_LAST) begin
          bar_cnt <= '0;
          if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_cnt <= bar_cnt + 1'b1;
        end
      end

      hdata       <= h;
      vdata       <= v;
      hsync       <= hsync_on ? HS_POL : ~HS_POL;
      vsync       <= vsync_on ? VS_POL : ~VS_POL;
      de          <= active;
      {red, green, blue} <= active ? pix : '0;
      frame_start <= pulse_frame;
      line_start  <= pulse_line;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: two small-raster instances (positive and negative sync) against a pixel-rule model.
module tb_video_pattern_gen;

  localparam int CW = 12;
  localparam int CL = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;

  always #5 clk = ~clk;

  logic [CW-1:0] a_hdata, a_vdata, b_hdata, b_vdata;
  logic          a_hsync, a_vsync, a_de, a_fs, a_ls;
  logic          b_hsync, b_vsync, b_de, b_fs, b_ls;
  logic [7:0]    a_red, a_green, a_blue, b_red, b_green, b_blue;

  video_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CHECK_LOG2(CL), .CW(CW)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .solid_rgb(solid_rgb),
    .hdata(a_hdata), .vdata(a_vdata), .hsync(a_hsync), .vsync(a_vsync), .de(a_de),
    .red(a_red), .green(a_green), .blue(a_blue), .frame_start(a_fs), .line_start(a_ls)
  );

  video_pattern_gen #(
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CHECK_LOG2(CL), .CW(CW)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .solid_rgb(solid_rgb),
    .hdata(b_hdata), .vdata(b_vdata), .hsync(b_hsync), .vsync(b_vsync), .de(b_de),
    .red(b_red), .green(b_green), .blue(b_blue), .frame_start(b_fs), .line_start(b_ls)
  );

  logic [52:0] obs [2];
  assign obs[0] = {a_hdata, a_vdata, a_hsync, a_vsync, a_de, a_red, a_green, a_blue, a_fs, a_ls};
  assign obs[1] = {b_hdata, b_vdata, b_hsync, b_vsync, b_de, b_red, b_green, b_blue, b_fs, b_ls};

  int checks = 0;
  int failures = 0;

  // Raster description of each instance.
  int ha [2] = '{16, 20};
  int hf [2] = '{2, 2};
  int hw [2] = '{3, 3};
  int hb [2] = '{3, 3};
  int va [2] = '{8, 8};
  int vf [2] = '{1, 1};
  int vw [2] = '{2, 2};
  int vb [2] = '{1, 1};
  bit pol [2] = '{1'b1, 1'b0};

  int          hm [2];
  int          vm [2];
  int          smode [2];
  logic [23:0] ssolid [2];
  logic [52:0] exp_v [2];

  function automatic logic [23:0] ref_pix(int h, int v, int md, logic [23:0] solid, int hact);
    int bar;
    logic [7:0] r, g, b;
    case (md)
      0: return {8'(h), 8'(v), 8'h5A};
      1: begin
        bar = h / (hact / 8);
        if (bar > 7) bar = 7;
        r = (bar == 0 || bar == 1 || bar == 4 || bar == 5) ? 8'hFF : 8'h00;
        g = (bar < 4) ? 8'hFF : 8'h00;
        b = (bar % 2 == 0) ? 8'hFF : 8'h00;
        return {r, g, b};
      end
      2: return ((((h >> CL) ^ (v >> CL)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return solid;
    endcase
  endfunction

  int   m_ht, m_vt;
  logic m_hs, m_vs, m_de;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_ht = ha[k] + hf[k] + hw[k] + hb[k];
      m_vt = va[k] + vf[k] + vw[k] + vb[k];
      if (reset) begin
        exp_v[k] = {24'd0, ~pol[k], ~pol[k], 1'b0, 24'd0, 2'b00};
        hm[k] = 0; vm[k] = 0; smode[k] = 0; ssolid[k] = '0;
      end else if (!enable) begin
        exp_v[k] = {12'(hm[k]), 12'(vm[k]), ~pol[k], ~pol[k], 1'b0, 24'd0, 2'b00};
      end else begin
        m_hs = (hm[k] >= ha[k] + hf[k]) && (hm[k] < ha[k] + hf[k] + hw[k]);
        m_vs = (vm[k] >= va[k] + vf[k]) && (vm[k] < va[k] + vf[k] + vw[k]);
        m_de = (hm[k] < ha[k]) && (vm[k] < va[k]);
        exp_v[k] = {12'(hm[k]), 12'(vm[k]),
                    m_hs ? pol[k] : ~pol[k], m_vs ? pol[k] : ~pol[k], m_de,
                    m_de ? ref_pix(hm[k], vm[k], smode[k], ssolid[k], ha[k]) : 24'd0,
                    (hm[k] == 0 && vm[k] == 0), (hm[k] == 0)};
        if (hm[k] == m_ht - 1) begin
          hm[k] = 0;
          if (vm[k] == m_vt - 1) begin
            vm[k] = 0;
            smode[k] = int'(mode);
            ssolid[k] = solid_rgb;
          end else begin
            vm[k] = vm[k] + 1;
          end
        end else begin
          hm[k] = hm[k] + 1;
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; mode = 2'd0; solid_rgb = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs[0] !== 53'd0) begin
      failures++; $display("FAIL reset_a got=%h exp=%h", obs[0], 53'd0);
    end
    checks++;
    if (obs[1] !== {24'd0, 2'b11, 27'd0}) begin
      failures++; $display("FAIL reset_b got=%h exp=%h", obs[1], {24'd0, 2'b11, 27'd0});
    end
    reset = 1'b0;
  endtask

  task automatic test_timing();
    int fa[$], fb[$];
    int de_a = 0, ls_a = 0, hs_a = 0, vs_a = 0, hs_b = 0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_v[k]) begin
          failures++; $display("FAIL timing_model dut%0d got=%h exp=%h", k, obs[k], exp_v[k]);
        end
      end
      if (c == 0) begin
        checks++;
        if (!(a_fs === 1'b1 && a_hdata === '0 && a_vdata === '0)) begin
          failures++; $display("FAIL first_pixel fs=%b h=%0d v=%0d exp fs=1 h=0 v=0", a_fs, a_hdata, a_vdata);
        end
      end
      if (a_fs) fa.push_back(c);
      if (b_fs) fb.push_back(c);
      if (c < 288) begin
        de_a += int'(a_de); ls_a += int'(a_ls); hs_a += int'(a_hsync); vs_a += int'(a_vsync);
      end
      if (c < 336) hs_b += int'(!b_hsync);
    end
    checks++;
    if (fa.size() < 2 || fa[1] - fa[0] != 288) begin
      failures++; $display("FAIL frame_period_a got=%0d exp=288", (fa.size() < 2) ? -1 : fa[1] - fa[0]);
    end
    checks++;
    if (fb.size() < 2 || fb[1] - fb[0] != 336) begin
      failures++; $display("FAIL frame_period_b got=%0d exp=336", (fb.size() < 2) ? -1 : fb[1] - fb[0]);
    end
    checks++;
    if (de_a != 128) begin failures++; $display("FAIL de_count got=%0d exp=128", de_a); end
    checks++;
    if (ls_a != 12) begin failures++; $display("FAIL line_count got=%0d exp=12", ls_a); end
    checks++;
    if (hs_a != 36) begin failures++; $display("FAIL hsync_count got=%0d exp=36", hs_a); end
    checks++;
    if (vs_a != 48) begin failures++; $display("FAIL vsync_count got=%0d exp=48", vs_a); end
    checks++;
    if (hs_b != 36) begin failures++; $display("FAIL hsync_low_count_b got=%0d exp=36", hs_b); end
  endtask

  task automatic test_bars();
    bit seen_b = 0;
    mode = 2'd1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_v[k]) begin
          failures++; $display("FAIL bars_model dut%0d got=%h exp=%h", k, obs[k], exp_v[k]);
        end
      end
      if (b_fs) seen_b = 1;
      if (seen_b && b_de && b_vdata == 12'd0) begin
        if (b_hdata == 12'd2) begin
          checks++;
          if ({b_red, b_green, b_blue} !== 24'hFFFF00) begin
            failures++; $display("FAIL bar_yellow got=%h exp=ffff00", {b_red, b_green, b_blue});
          end
        end
        if (b_hdata == 12'd13) begin
          checks++;
          if ({b_red, b_green, b_blue} !== 24'h0000FF) begin
            failures++; $display("FAIL bar_blue got=%h exp=0000ff", {b_red, b_green, b_blue});
          end
        end
        if (b_hdata == 12'd19) begin
          checks++;
          if ({b_red, b_green, b_blue} !== 24'h000000) begin
            failures++; $display("FAIL bar_remainder got=%h exp=000000", {b_red, b_green, b_blue});
          end
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    int phase = 0;
    mode = 2'd0;
    for (int c = 0; c < 900 && phase < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_v[k]) begin
          failures++; $display("FAIL switch_model dut%0d got=%h exp=%h", k, obs[k], exp_v[k]);
        end
      end
      if (phase == 0 && a_fs) phase = 1;
      else if (phase == 1 && a_vdata == 12'd3) begin mode = 2'd2; phase = 2; end
      else if (phase == 2 && a_de && a_vdata == 12'd0 && a_hdata == 12'd2) begin
        checks++;
        if ({a_red, a_green, a_blue} !== 24'hFFFFFF) begin
          failures++; $display("FAIL checker_after_switch got=%h exp=ffffff", {a_red, a_green, a_blue});
        end
        phase = 3;
      end
    end
    checks++;
    if (phase != 3) begin failures++; $display("FAIL switch_timeout phase=%0d exp=3", phase); end
  endtask

  task automatic test_solid();
    bit seen = 0;
    int good = 0, bad = 0;
    solid_rgb = 24'h123456;
    mode = 2'd3;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_v[k]) begin
          failures++; $display("FAIL solid_model dut%0d got=%h exp=%h", k, obs[k], exp_v[k]);
        end
      end
      if (a_fs) seen = 1;
      if (seen && a_de) begin
        if ({a_red, a_green, a_blue} === 24'h123456) good++; else bad++;
      end
    end
    checks++;
    if (bad != 0 || good == 0) begin
      failures++; $display("FAIL solid_pixels good=%0d bad=%0d exp bad=0", good, bad);
    end
  endtask

  task automatic test_enable();
    int phase = 0, cnt = 0;
    for (int c = 0; c < 600 && phase < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_v[k]) begin
          failures++; $display("FAIL enable_model dut%0d got=%h exp=%h", k, obs[k], exp_v[k]);
        end
      end
      if (phase == 0 && a_de && a_hdata == 12'd4 && a_vdata == 12'd2) begin
        enable = 1'b0; phase = 1;
      end else if (phase == 1) begin
        cnt++;
        checks++;
        if ({a_de, a_red, a_green, a_blue, a_hsync, a_vsync, a_fs, a_ls} !== 29'd0) begin
          failures++; $display("FAIL disabled_out de=%b rgb=%h hs=%b vs=%b exp all 0",
                               a_de, {a_red, a_green, a_blue}, a_hsync, a_vsync);
        end
        if (cnt == 10) begin enable = 1'b1; phase = 2; end
      end else if (phase == 2) begin
        checks++;
        if (!(a_hdata === 12'd5 && a_vdata === 12'd2 && a_de === 1'b1)) begin
          failures++; $display("FAIL resume_pos h=%0d v=%0d de=%b exp h=5 v=2 de=1", a_hdata, a_vdata, a_de);
        end
        phase = 3;
      end
    end
    checks++;
    if (phase != 3) begin failures++; $display("FAIL enable_timeout phase=%0d exp=3", phase); end
    enable = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_v[k]) begin
          failures++; $display("FAIL random_model dut%0d got=%h exp=%h", k, obs[k], exp_v[k]);
        end
      end
      enable = ($urandom % 8) != 0;
      if ($urandom % 50 == 0) mode = 2'($urandom);
      if ($urandom % 40 == 0) solid_rgb = 24'($urandom);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int phase = 0;
    for (int c = 0; c < 600 && phase < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_v[k]) begin
          failures++; $display("FAIL rstmid_model dut%0d got=%h exp=%h", k, obs[k], exp_v[k]);
        end
      end
      if (phase == 0 && a_de && a_hdata == 12'd9 && a_vdata == 12'd4) begin
        reset = 1'b1; mode = 2'd2; phase = 1;
      end else if (phase == 1) begin
        checks++;
        if (obs[0] !== 53'd0) begin
          failures++; $display("FAIL rstmid_values got=%h exp=%h", obs[0], 53'd0);
        end
        reset = 1'b0; phase = 2;
      end else if (phase == 2) begin
        checks++;
        if (!(a_hdata === '0 && a_vdata === '0 && a_fs === 1'b1 && a_de === 1'b1 &&
              {a_red, a_green, a_blue} === 24'h00005A)) begin
          failures++; $display("FAIL rstmid_first h=%0d v=%0d fs=%b rgb=%h exp h=0 v=0 fs=1 rgb=00005a",
                               a_hdata, a_vdata, a_fs, {a_red, a_green, a_blue});
        end
        phase = 3;
      end
    end
    checks++;
    if (phase != 3) begin failures++; $display("FAIL rstmid_timeout phase=%0d exp=3", phase); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_bars();
    test_mode_switch();
    test_solid();
    test_enable();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
